// File: rtl/key_event_gen.sv
// Turns a debounced key level into one-cycle press/release/click/long-press/repeat pulses.
// All outputs come from flops; the event decode is a small three-state FSM with a hold counter.
module key_event_gen #(
  parameter int unsigned LONG_CYC   = 25000000,
  parameter int unsigned REPEAT_CYC = 5000000,
  parameter int unsigned CNT_W      = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic key_level,
  input  logic en,
  output logic held,
  output logic press,
  output logic release_evt,
  output logic click,
  output logic long_press,
  output logic repeat_evt
);

  typedef enum logic [1:0] {IDLE, SHORT, LONG} state_t;

  localparam logic [CNT_W-1:0] LONG_TH = CNT_W'(LONG_CYC);
  localparam logic [CNT_W-1:0] REP_TH  = CNT_W'(REPEAT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_n;
  logic [CNT_W-1:0] hold_cnt, cnt_n;
  logic             key_d;
  logic             rise, fall;

  // {press, release, click, long_press, repeat}
  logic [4:0]       ev_p0;
  logic [4:0]       ev_p1;

  // stage p0: edge detect and next-state / event decode
  always_comb begin
    rise    = key_level & ~key_d;
    fall    = ~key_level & key_d;
    state_n = state_q;
    cnt_n   = hold_cnt;
    ev_p0   = 5'b00000;
    unique case (state_q)
      IDLE: begin
        cnt_n = '0;
        if (rise) begin
          ev_p0[4] = 1'b1;
          cnt_n    = CNT_ONE;
          state_n  = SHORT;
        end
      end
      SHORT: begin
        if (fall) begin
          ev_p0[3] = 1'b1;
          ev_p0[2] = 1'b1;
          cnt_n    = '0;
          state_n  = IDLE;
        end else if (hold_cnt == LONG_TH) begin
          ev_p0[1] = 1'b1;
          cnt_n    = CNT_ONE;
          state_n  = LONG;
        end else begin
          cnt_n = hold_cnt + CNT_ONE;
        end
      end
      LONG: begin
        // a release on the threshold cycle suppresses the repeat
        if (fall) begin
          ev_p0[3] = 1'b1;
          cnt_n    = '0;
          state_n  = IDLE;
        end else if (hold_cnt == REP_TH) begin
          ev_p0[0] = 1'b1;
          cnt_n    = CNT_ONE;
        end else begin
          cnt_n = hold_cnt + CNT_ONE;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // stage p1: registered state, counter and gated pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      hold_cnt <= '0;
      key_d    <= 1'b0;
      ev_p1    <= 5'b00000;
    end else begin
      state_q  <= state_n;
      hold_cnt <= cnt_n;
      key_d    <= key_level;
      ev_p1    <= ev_p0 & {5{en}};
    end
  end

  assign held        = key_d;
  assign press       = ev_p1[4];
  assign release_evt = ev_p1[3];
  assign click       = ev_p1[2];
  assign long_press  = ev_p1[1];
  assign repeat_evt  = ev_p1[0];

endmodule

// File: tb/tb_key_event_gen.sv
// Directed scoreboard bench for key_event_gen with LONG_CYC=10, REPEAT_CYC=4.
// Expected pulses are queued with their cycle number; a negedge monitor pops and compares.
module tb_key_event_gen;

  localparam logic [4:0] P  = 5'b10000;
  localparam logic [4:0] R  = 5'b01000;
  localparam logic [4:0] C  = 5'b00100;
  localparam logic [4:0] L  = 5'b00010;
  localparam logic [4:0] RP = 5'b00001;

  logic clk = 1'b0;
  logic rst;
  logic key_level;
  logic en;
  logic held, press, release_evt, click, long_press, repeat_evt;

  typedef struct {
    int         cyc;
    logic [4:0] ev;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   t0  = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  key_event_gen #(
    .LONG_CYC  (10),
    .REPEAT_CYC(4),
    .CNT_W     (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_level  (key_level),
    .en         (en),
    .held       (held),
    .press      (press),
    .release_evt(release_evt),
    .click      (click),
    .long_press (long_press),
    .repeat_evt (repeat_evt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every nonzero pulse vector must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [4:0] ev;
    exp_t e;
    ev = {press, release_evt, click, long_press, repeat_evt};
    if (ev != 5'b00000) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse: cycle %0d got %b, expected no pulse", cyc - t0, ev);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc || e.ev != ev) begin
          n_err++;
          $display("FAIL pulse: got %b at cycle %0d, expected %b at cycle %0d",
                   ev, cyc - t0, e.ev, e.cyc - t0);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Block until the negedge just before test-relative edge n.
  task automatic goto(input int n);
    while (cyc < t0 + n - 1) @(negedge clk);
  endtask

  task automatic expect_ev(input int n, input logic [4:0] ev);
    exp_t e;
    e.cyc = t0 + n;
    e.ev  = ev;
    sb.push_back(e);
  endtask

  task automatic start_test();
    @(negedge clk);
    t0 = cyc;
  endtask

  task automatic end_test(input string name, input int len);
    goto(len);
    @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s_missing: %0d expected pulse(s) never seen, first at cycle %0d",
               name, sb.size(), sb[0].cyc - t0);
      sb.delete();
    end
  endtask

  task automatic hold_test(input int hi_from, input int hi_to);
    goto(hi_from);
    key_level = 1'b1;
    goto(hi_to + 1);
    key_level = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    key_level = 1'b0;
    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {26'd0, held, press, release_evt, click, long_press, repeat_evt}, 32'd0);
    rst = 1'b0;

    // T1: idle key after reset, nothing may pulse
    start_test();
    for (int n = 1; n <= 20; n++) begin
      goto(n);
      chk("idle_outputs", {26'd0, held, press, release_evt, click, long_press, repeat_evt}, 32'd0);
    end
    end_test("idle", 22);

    // T2: short hold edges 5..10, held follows with one-cycle latency
    start_test();
    expect_ev(5, P);
    expect_ev(11, R | C);
    for (int n = 1; n <= 15; n++) begin
      goto(n);
      chk("short_held", {31'd0, held}, {31'd0, ((n - 1) >= 5 && (n - 1) <= 10)});
      key_level = (n >= 5 && n <= 10);
    end
    end_test("short", 20);

    // T3: 30-cycle hold into long press and auto-repeat
    start_test();
    expect_ev(5, P);
    expect_ev(15, L);
    expect_ev(19, RP);
    expect_ev(23, RP);
    expect_ev(27, RP);
    expect_ev(31, RP);
    expect_ev(35, R);
    hold_test(5, 34);
    end_test("long", 42);

    // T4: release on the very edge long_press would fire
    start_test();
    expect_ev(5, P);
    expect_ev(15, R | C);
    hold_test(5, 14);
    end_test("edge_release", 22);

    // T5: events disabled during the hold, re-enabled just before release
    start_test();
    en = 1'b0;
    expect_ev(35, R);
    goto(5);
    key_level = 1'b1;
    goto(21);
    chk("disabled_held", {31'd0, held}, 32'd1);
    goto(33);
    en = 1'b1;
    goto(35);
    key_level = 1'b0;
    end_test("disabled", 42);

    // T6: reset mid-hold, key still high afterwards gives a fresh press
    start_test();
    expect_ev(5, P);
    expect_ev(15, L);
    expect_ev(19, P);
    expect_ev(29, L);
    expect_ev(33, RP);
    expect_ev(35, R);
    goto(5);
    key_level = 1'b1;
    goto(17);
    rst = 1'b1;
    goto(18);
    chk("midreset_outputs", {26'd0, held, press, release_evt, click, long_press, repeat_evt}, 32'd0);
    goto(19);
    rst = 1'b0;
    goto(35);
    key_level = 1'b0;
    end_test("midreset", 42);

    // T7: one-cycle glitch passes straight through as press then release/click
    start_test();
    expect_ev(5, P);
    expect_ev(6, R | C);
    hold_test(5, 5);
    end_test("glitch", 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
